ps2_joypad: RTL and testbench

PS/2 set-2 scancode decoder that turns the keyboard controller's byte stream (`ps2data`/`ps2hit`) into the active-low Gigatron input register (`inreg`) consumed by the `gigatron` core. It sits between `keyboard` and `gigatron` in the DE0 top level, in the 50 MHz domain. It replaces ad-hoc release handling with per-button press tracking, `E0`/`F0`/`E1` prefix decoding and, optionally, timed ASCII injection.

---
 rtl/ps2_joypad.sv | 193 +++++++++++++++++++
 tb/tb_ps2_joypad.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_joypad.sv
// PS/2 set-2 scancode decoder driving the active-low Gigatron input register.
// Optional timed ASCII injection is compiled in with `define PS2PAD_ASCII_EN.
module ps2_joypad #(
  parameter int unsigned HOLD_FRAMES = 3
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] ps2data,
  input  logic       ps2hit,
  input  logic       vsync,
  output logic [7:0] inreg,
  output logic       ascii_active
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_skip_cnt, w_skip_nxt;
  logic       w_make, w_brk, w_ext;
  logic [7:0] r_pad, w_pad_nxt, w_pad_mask;
  logic       r_vs_meta, r_vs_sync, r_vs_prev;
  logic       w_vs_fall;

  function automatic logic [7:0] pad_mask(input logic [7:0] code);
    case (code)
      8'h74:   pad_mask = 8'h01;
      8'h6B:   pad_mask = 8'h02;
      8'h72:   pad_mask = 8'h04;
      8'h75:   pad_mask = 8'h08;
      8'h69:   pad_mask = 8'h10;
      8'h71:   pad_mask = 8'h20;
      8'h70:   pad_mask = 8'h40;
      8'h6C:   pad_mask = 8'h80;
      default: pad_mask = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_skip_cnt <= 3'd0;
      r_pad      <= 8'h00;
      r_vs_meta  <= 1'b1;
      r_vs_sync  <= 1'b1;
      r_vs_prev  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
      r_pad      <= w_pad_nxt;
      r_vs_meta  <= vsync;
      r_vs_sync  <= r_vs_meta;
      r_vs_prev  <= r_vs_sync;
    end
  end

  assign w_vs_fall = r_vs_prev & ~r_vs_sync;

  // Prefix FSM: classifies each byte as make/break, extended or not.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (ps2hit) begin
      case (r_state)
        S_IDLE: begin
          if (ps2data == 8'hE0)      w_state_nxt = S_EXT;
          else if (ps2data == 8'hF0) w_state_nxt = S_BRK;
          else if (ps2data == 8'hE1) begin
            w_state_nxt = S_SKIP;
            w_skip_nxt  = 3'd7;
          end else                   w_make = 1'b1;
        end
        S_EXT: begin
          if (ps2data == 8'hF0) w_state_nxt = S_EXT_BRK;
          else begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          w_brk       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          w_brk       = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_SKIP: begin
          w_skip_nxt = r_skip_cnt - 3'd1;
          if (r_skip_cnt <= 3'd1) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pad_mask = pad_mask(ps2data);
    w_pad_nxt  = r_pad;
    if (w_make)     w_pad_nxt = r_pad | w_pad_mask;
    else if (w_brk) w_pad_nxt = r_pad & ~w_pad_mask;
  end

`ifdef PS2PAD_ASCII_EN
  logic       r_lshift, r_rshift;
  logic [7:0] r_hold, w_hold_nxt;
  logic [7:0] r_ascii, w_ascii_nxt;
  logic [8:0] w_asc;
  logic       w_load;

  // Returns {valid, ascii}; letters are stored upper case and lowered via bit 5.
  function automatic logic [8:0] ascii_of(input logic [7:0] code, input logic shift);
    logic [7:0] up;
    logic       letter;
    logic [8:0] res;
    up     = 8'h00;
    letter = 1'b1;
    res    = 9'h000;
    case (code)
      8'h1C: up = 8'h41;  8'h32: up = 8'h42;  8'h21: up = 8'h43;  8'h23: up = 8'h44;
      8'h24: up = 8'h45;  8'h2B: up = 8'h46;  8'h34: up = 8'h47;  8'h33: up = 8'h48;
      8'h43: up = 8'h49;  8'h3B: up = 8'h4A;  8'h42: up = 8'h4B;  8'h4B: up = 8'h4C;
      8'h3A: up = 8'h4D;  8'h31: up = 8'h4E;  8'h44: up = 8'h4F;  8'h4D: up = 8'h50;
      8'h15: up = 8'h51;  8'h2D: up = 8'h52;  8'h1B: up = 8'h53;  8'h2C: up = 8'h54;
      8'h3C: up = 8'h55;  8'h2A: up = 8'h56;  8'h1D: up = 8'h57;  8'h22: up = 8'h58;
      8'h35: up = 8'h59;  8'h1A: up = 8'h5A;
      default: letter = 1'b0;
    endcase
    if (letter) res = {1'b1, shift ? up : (up | 8'h20)};
    else begin
      case (code)
        8'h45: res = 9'h130;  8'h16: res = 9'h131;  8'h1E: res = 9'h132;
        8'h26: res = 9'h133;  8'h25: res = 9'h134;  8'h2E: res = 9'h135;
        8'h36: res = 9'h136;  8'h3D: res = 9'h137;  8'h3E: res = 9'h138;
        8'h46: res = 9'h139;  8'h29: res = 9'h120;  8'h5A: res = 9'h10A;
        8'h66: res = 9'h17F;
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  always_comb begin
    w_asc       = ascii_of(ps2data, r_lshift | r_rshift);
    w_load      = w_make & ~w_ext & w_asc[8];
    w_ascii_nxt = w_load ? w_asc[7:0] : r_ascii;
    w_hold_nxt  = r_hold;
    // A reload in the same cycle as a vsync edge takes priority over the decrement.
    if (w_load)                            w_hold_nxt = HOLD_INIT;
    else if (w_vs_fall && r_hold != 8'd0)  w_hold_nxt = r_hold - 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_lshift     <= 1'b0;
      r_rshift     <= 1'b0;
      r_hold       <= 8'd0;
      r_ascii      <= 8'h00;
      inreg        <= 8'hFF;
      ascii_active <= 1'b0;
    end else begin
      if (!w_ext && ps2data == 8'h12 && (w_make || w_brk)) r_lshift <= w_make;
      if (!w_ext && ps2data == 8'h59 && (w_make || w_brk)) r_rshift <= w_make;
      r_hold       <= w_hold_nxt;
      r_ascii      <= w_ascii_nxt;
      inreg        <= (w_hold_nxt != 8'd0) ? w_ascii_nxt : ~w_pad_nxt;
      ascii_active <= (w_hold_nxt != 8'd0);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{HOLD_INIT, w_vs_fall, w_ext};
  assign ascii_active = 1'b0;

  always_ff @(posedge clock) begin
    if (!rst_n) inreg <= 8'hFF;
    else        inreg <= ~w_pad_nxt;
  end
`endif

endmodule

// File: tb/tb_ps2_joypad.sv
// Directed bench for ps2_joypad; covers the ASCII path when PS2PAD_ASCII_EN is defined.
module tb_ps2_joypad;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2data = 8'h00;
  logic       ps2hit = 1'b0;
  logic       vsync = 1'b1;
  logic [7:0] inreg;
  logic       ascii_active;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_joypad #(.HOLD_FRAMES(3)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .ps2data      (ps2data),
    .ps2hit       (ps2hit),
    .vsync        (vsync),
    .inreg        (inreg),
    .ascii_active (ascii_active)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2data = b;
    ps2hit  = 1'b1;
    @(negedge clock);
    ps2hit  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic vs_edge();
    @(negedge clock);
    vsync = 1'b0;
    repeat (5) @(negedge clock);
    vsync = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    logic [7:0] codes [8];
    logic [7:0] acc;
    codes = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h69, 8'h71, 8'h70, 8'h6C};

    do_reset();
    check("reset_inreg", inreg, 8'hFF);
    check("reset_active", {7'd0, ascii_active}, 8'h00);

    // Extended make/break of RIGHT
    send(8'hE0);
    check("prefix_e0", inreg, 8'hFF);
    send(8'h74);
    check("ext_make_right", inreg, 8'hFE);
    send(8'hE0); send(8'hF0);
    check("prefix_e0f0", inreg, 8'hFE);
    send(8'h74);
    check("ext_break_right", inreg, 8'hFF);

    // Independent per-button tracking
    send(8'h6B);
    check("make_left", inreg, 8'hFD);
    send(8'h75);
    check("make_up", inreg, 8'hF5);
    send(8'hF0); send(8'h6B);
    check("break_left", inreg, 8'hF7);
    send(8'hF0); send(8'h75);
    check("break_up", inreg, 8'hFF);

    // Every mapped bit, pressed cumulatively then released one by one
    acc = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      send(codes[i]);
      acc[i] = 1'b0;
      check($sformatf("map_make_%0d", i), inreg, acc);
    end
    for (int i = 0; i < 8; i++) begin
      send(8'hF0); send(codes[i]);
      acc[i] = 1'b1;
      check($sformatf("map_break_%0d", i), inreg, acc);
    end

    // Pause sequence is swallowed, next byte decodes normally
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_skip", inreg, 8'hFF);
    send(8'h72);
    check("after_pause_down", inreg, 8'hFB);
    send(8'hF0); send(8'h72);
    check("break_down", inreg, 8'hFF);

    // Fake shifts and unmapped codes leave pad alone
    send(8'hE0); send(8'h12);
    check("fake_shift", inreg, 8'hFF);
    send(8'h05);
    check("unmapped", inreg, 8'hFF);

    // Reset aborts a pending prefix
    send(8'h74);
    check("pre_abort_right", inreg, 8'hFE);
    send(8'hE0);
    @(negedge clock); rst_n = 1'b0;
    @(negedge clock); rst_n = 1'b1;
    check("abort_reset", inreg, 8'hFF);
    send(8'hF0); send(8'h74);
    check("abort_break", inreg, 8'hFF);
    send(8'h6C);
    check("abort_then_a", inreg, 8'h7F);

    // Strobe during reset is ignored
    @(negedge clock);
    rst_n = 1'b0; ps2data = 8'h69; ps2hit = 1'b1;
    @(negedge clock);
    ps2hit = 1'b0; rst_n = 1'b1;
    @(negedge clock);
    check("hit_in_reset", inreg, 8'hFF);

`ifdef PS2PAD_ASCII_EN
    send(8'h12); send(8'h1C);
    check("ascii_A", inreg, 8'h41);
    check("ascii_A_active", {7'd0, ascii_active}, 8'h01);
    vs_edge();
    check("hold_edge1", inreg, 8'h41);
    vs_edge();
    check("hold_edge2", inreg, 8'h41);
    send(8'h32);
    check("reload_B", inreg, 8'h42);
    send(8'h74);
    check("pad_hidden", inreg, 8'h42);
    vs_edge();
    check("reload_edge1", inreg, 8'h42);
    vs_edge();
    check("reload_edge2", inreg, 8'h42);
    check("reload_edge2_active", {7'd0, ascii_active}, 8'h01);
    vs_edge();
    check("hold_end", inreg, 8'hFE);
    check("hold_end_active", {7'd0, ascii_active}, 8'h00);
    send(8'hF0); send(8'h74);
    send(8'hF0); send(8'h12);
    send(8'hE0); send(8'h12);
    send(8'h1C);
    check("ascii_a_lower", inreg, 8'h61);
    send(8'hF0); send(8'h1C);
    check("ascii_break_ignored", inreg, 8'h61);
    send(8'h16);
    check("ascii_digit1", inreg, 8'h31);
    send(8'h5A);
    check("ascii_enter", inreg, 8'h0A);
    repeat (3) vs_edge();
    check("ascii_done", inreg, 8'hFF);
    check("ascii_done_active", {7'd0, ascii_active}, 8'h00);
`else
    send(8'h1C);
    check("no_ascii_1C", inreg, 8'hFF);
    check("no_ascii_active", {7'd0, ascii_active}, 8'h00);
    send(8'h12); send(8'h1C);
    vs_edge();
    check("no_ascii_vsync", inreg, 8'hFF);
    check("no_ascii_active2", {7'd0, ascii_active}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
